// File: rtl/lab1_imul_mul_accum_pkg.sv
// Shared types and helpers for the product accumulator.
package lab1_imul_mul_accum_pkg;

    // Control FSM states: collecting products, or holding a finished sum.
    typedef enum logic {
        STATE_ACCUM = 1'b0,
        STATE_DONE  = 1'b1
    } state_t;

    // Width of the per-group product counter.
    function automatic int unsigned count_width(input int unsigned nprods);
        return $clog2(nprods + 1);
    endfunction

endpackage

// File: rtl/lab1_imul_mul_accum_dpath.sv
// Accumulator datapath: running sum, group counter and the held output sum.
module lab1_imul_mul_accum_dpath
    import lab1_imul_mul_accum_pkg::*;
#(
    parameter int unsigned p_nprods = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_msg,
    input  logic        i_acc_clear,
    input  logic        i_acc_en,
    input  logic        i_sum_en,
    output logic        o_count_is_last,
    output logic [31:0] o_sum
);

    localparam int unsigned CountW = count_width(p_nprods);

    logic [31:0]       r_acc;
    logic [31:0]       r_sum;
    logic [CountW-1:0] r_count;
    logic [31:0]       w_add;

    // Carry out is dropped, so the sum wraps modulo 2^32.
    assign w_add           = r_acc + i_msg;
    assign o_count_is_last = (r_count == CountW'(p_nprods - 1));
    assign o_sum           = r_sum;

    // Running sum and product counter; clear wins over accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_acc_clear) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_acc_en) begin
            r_acc   <= w_add;
            r_count <= r_count + CountW'(1);
        end
    end

    // Finished group sum, held stable until the sink takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else if (i_sum_en) begin
            r_sum <= w_add;
        end
    end

endmodule

// File: rtl/lab1_imul_mul_accum.sv
// Product accumulator: sums each group of p_nprods products and emits one sum
// per group. Control FSM lives here; registers and adder live in the datapath.
module lab1_imul_mul_accum
    import lab1_imul_mul_accum_pkg::*;
#(
    parameter int unsigned p_nprods = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        istream_val,
    output logic        istream_rdy,
    input  logic [31:0] istream_msg,
    output logic        ostream_val,
    input  logic        ostream_rdy,
    output logic [31:0] ostream_msg
);

    state_t r_state;
    state_t w_state_next;
    logic   w_acc_clear;
    logic   w_acc_en;
    logic   w_sum_en;
    logic   w_count_is_last;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STATE_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and control; handshakes depend on state only, masked by reset.
    always_comb begin
        w_state_next = r_state;
        istream_rdy  = 1'b0;
        ostream_val  = 1'b0;
        w_acc_clear  = 1'b0;
        w_acc_en     = 1'b0;
        w_sum_en     = 1'b0;
        unique case (r_state)
            STATE_ACCUM: begin
                istream_rdy = !reset;
                if (istream_val && !reset) begin
                    if (w_count_is_last) begin
                        w_sum_en     = 1'b1;
                        w_acc_clear  = 1'b1;
                        w_state_next = STATE_DONE;
                    end else begin
                        w_acc_en = 1'b1;
                    end
                end
            end
            STATE_DONE: begin
                ostream_val = !reset;
                if (ostream_rdy) begin
                    w_state_next = STATE_ACCUM;
                end
            end
        endcase
    end

    lab1_imul_mul_accum_dpath #(
        .p_nprods (p_nprods)
    ) u_dpath (
        .clk             (clk),
        .reset           (reset),
        .i_msg           (istream_msg),
        .i_acc_clear     (w_acc_clear),
        .i_acc_en        (w_acc_en),
        .i_sum_en        (w_sum_en),
        .o_count_is_last (w_count_is_last),
        .o_sum           (ostream_msg)
    );

endmodule

// File: tb/tb_lab1_imul_mul_accum.sv
// Bench for the product accumulator: instance 0 groups 4 products, instance 1
// groups 1. A group-sum model is checked against both on every cycle.
module tb_lab1_imul_mul_accum;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        in_val  [2];
    logic        in_rdy  [2];
    logic [31:0] in_msg  [2];
    logic        out_val [2];
    logic        out_rdy [2];
    logic [31:0] out_msg [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fire [2];

    // Model state: partial group sum, products seen in the group, pending sum.
    logic [31:0] m_part  [2];
    int          m_cnt   [2];
    logic        m_have  [2];
    logic [31:0] m_sum   [2];
    int          m_taken [2];

    always #5 clk = ~clk;

    lab1_imul_mul_accum #(.p_nprods(4)) dut0 (
        .clk(clk), .reset(reset),
        .istream_val(in_val[0]), .istream_rdy(in_rdy[0]), .istream_msg(in_msg[0]),
        .ostream_val(out_val[0]), .ostream_rdy(out_rdy[0]), .ostream_msg(out_msg[0])
    );

    lab1_imul_mul_accum #(.p_nprods(1)) dut1 (
        .clk(clk), .reset(reset),
        .istream_val(in_val[1]), .istream_rdy(in_rdy[1]), .istream_msg(in_msg[1]),
        .ostream_val(out_val[1]), .ostream_rdy(out_rdy[1]), .ostream_msg(out_msg[1])
    );

    function automatic int nprods(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: a product is accepted whenever no sum is pending; the Nth product of a
    // group turns the running total into a pending sum, which the sink removes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_part[i] <= '0;
                m_cnt[i]  <= 0;
                m_have[i] <= 1'b0;
            end else if (m_have[i]) begin
                if (out_rdy[i]) begin
                    m_have[i]  <= 1'b0;
                    m_taken[i] <= m_taken[i] + 1;
                end
            end else if (in_val[i]) begin
                if (m_cnt[i] + 1 == nprods(i)) begin
                    m_sum[i]  <= m_part[i] + in_msg[i];
                    m_have[i] <= 1'b1;
                    m_part[i] <= '0;
                    m_cnt[i]  <= 0;
                end else begin
                    m_part[i] <= m_part[i] + in_msg[i];
                    m_cnt[i]  <= m_cnt[i] + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check32($sformatf("istream_rdy[%0d]", i), {31'b0, in_rdy[i]},
                    {31'b0, !reset && !m_have[i]});
            check32($sformatf("ostream_val[%0d]", i), {31'b0, out_val[i]},
                    {31'b0, !reset && m_have[i]});
            if (!reset && m_have[i]) begin
                check32($sformatf("ostream_msg[%0d]", i), out_msg[i], m_sum[i]);
            end
        end
    end

    // Offer one product after dly idle cycles; returns just after the fire edge.
    task automatic put(input int i, input logic [31:0] m, input int dly);
        logic fired;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        in_val[i] = 1'b1;
        in_msg[i] = m;
        fired = 1'b0;
        for (int n = 0; n < 100 && !fired; n++) begin
            @(negedge clk);
            fired = in_rdy[i];
            @(posedge clk);
            #1;
        end
        in_val[i] = 1'b0;
        in_msg[i] = $urandom();
        if (fired) last_fire[i] = cyc;
        check32("put handshake", {31'b0, fired}, 32'd1);
    endtask

    // Wait for an output transfer and compare it with a hand-computed sum.
    task automatic expect_out(input int i, input logic [31:0] exp, input string name);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (out_val[i] && out_rdy[i]) begin
                seen = 1'b1;
                check32(name, out_msg[i], exp);
            end
            @(posedge clk);
            #1;
        end
        check32({name, " seen"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic src_done;
        int   base;
        for (int i = 0; i < 2; i++) begin
            in_val[i]  = 1'b0;
            in_msg[i]  = '0;
            out_rdy[i] = 1'b1;
            m_part[i]  = '0;
            m_cnt[i]   = 0;
            m_have[i]  = 1'b0;
            m_sum[i]   = '0;
            m_taken[i] = 0;
            last_fire[i] = 0;
        end

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check32("reset rdy", {31'b0, in_rdy[0]}, 32'd0);
        check32("reset val", {31'b0, out_val[0]}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check32("post-reset rdy", {31'b0, in_rdy[0]}, 32'd1);
        check32("post-reset val", {31'b0, out_val[0]}, 32'd0);
        check32("post-reset sum", out_msg[0], 32'd0);
        tick();

        // Basic group, back-to-back, sink always ready
        put(0, 32'd1, 0);
        put(0, 32'd2, 0);
        put(0, 32'd3, 0);
        put(0, 32'd4, 0);
        @(negedge clk);
        check32("basic sum", out_msg[0], 32'h0000000a);
        check32("basic val", {31'b0, out_val[0]}, 32'd1);
        check32("basic rdy low", {31'b0, in_rdy[0]}, 32'd0);
        tick();
        @(negedge clk);
        check32("basic rdy back", {31'b0, in_rdy[0]}, 32'd1);
        tick();

        // Wrap-around
        put(0, 32'hffffffff, 0);
        put(0, 32'h00000002, 0);
        put(0, 32'h80000000, 0);
        put(0, 32'h80000000, 0);
        expect_out(0, 32'h00000001, "wrap sum");
        // -3 + 5 - 7 + 2 = -3
        put(0, -32'sd3, 0);
        put(0, 32'sd5, 0);
        put(0, -32'sd7, 0);
        put(0, 32'sd2, 0);
        expect_out(0, 32'hfffffffd, "signed sum a");
        // -3 + 5 - 7 - 2 = -7
        put(0, -32'sd3, 1);
        put(0, 32'sd5, 0);
        put(0, -32'sd7, 2);
        put(0, -32'sd2, 0);
        expect_out(0, 32'hfffffff9, "signed sum b");

        // Back-pressure: sum held for 5 cycles
        out_rdy[0] = 1'b0;
        put(0, 32'd10, 0);
        put(0, 32'd20, 0);
        put(0, 32'd30, 0);
        put(0, 32'd40, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check32("stall val", {31'b0, out_val[0]}, 32'd1);
            check32("stall msg", out_msg[0], 32'h00000064);
            check32("stall rdy", {31'b0, in_rdy[0]}, 32'd0);
            tick();
        end
        out_rdy[0] = 1'b1;
        expect_out(0, 32'h00000064, "stall release sum");
        put(0, 32'd1, 0);
        put(0, 32'd1, 0);
        put(0, 32'd1, 0);
        put(0, 32'd1, 0);
        expect_out(0, 32'h00000004, "after stall sum");

        // Random source and sink delays, 50 groups, checked by the model
        base = m_taken[0];
        src_done = 1'b0;
        fork
            begin
                for (int g = 0; g < 50; g++) begin
                    for (int k = 0; k < 4; k++) begin
                        put(0, $urandom(), $urandom_range(0, 3));
                    end
                end
                src_done = 1'b1;
            end
            begin
                while (!src_done) begin
                    tick();
                    out_rdy[0] = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_rdy[0] = 1'b1;
        for (int n = 0; n < 50 && m_taken[0] != base + 50; n++) tick();
        check32("random sums taken", m_taken[0] - base, 32'd50);
        check32("random none pending", {31'b0, m_have[0]}, 32'd0);

        // Reset mid-group
        put(0, 32'd1, 0);
        put(0, 32'd2, 0);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check32("mid reset rdy", {31'b0, in_rdy[0]}, 32'd0);
            check32("mid reset val", {31'b0, out_val[0]}, 32'd0);
            tick();
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) put(0, 32'd5, 0);
        expect_out(0, 32'h00000014, "after mid reset sum");

        // Reset while holding a sum
        out_rdy[0] = 1'b0;
        put(0, 32'd1, 0);
        put(0, 32'd2, 0);
        put(0, 32'd3, 0);
        put(0, 32'd4, 0);
        @(negedge clk);
        check32("done before reset", {31'b0, out_val[0]}, 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check32("done reset rdy", {31'b0, in_rdy[0]}, 32'd0);
        check32("done reset val", {31'b0, out_val[0]}, 32'd0);
        tick();
        reset = 1'b0;
        out_rdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) put(0, 32'd5, 0);
        expect_out(0, 32'h00000014, "after done reset sum");

        // One product per group
        begin
            int f1;
            out_rdy[1] = 1'b1;
            put(1, 32'd7, 0);
            f1 = last_fire[1];
            @(negedge clk);
            check32("n1 first val", {31'b0, out_val[1]}, 32'd1);
            check32("n1 first sum", out_msg[1], 32'd7);
            tick();
            put(1, 32'd9, 0);
            check32("n1 fire spacing", last_fire[1] - f1, 32'd2);
            @(negedge clk);
            check32("n1 second sum", out_msg[1], 32'd9);
            tick();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
